lifo_top_cache: RTL and testbench
=================================

Name: lifo_top_cache

Overview:
Stream-facing front end for lifo_controller. It holds the top-of-stack entry in a local register and keeps every older entry in the attached LIFO.
- Push side and pop side are valid/ready; m_data is driven straight from a flop.
- Strict LIFO order is preserved.
- Total capacity is DEPTH+1 (register plus LIFO).
- The block drives the LIFO's write_enable/write_data/read_enable and consumes its full/empty/read_data.

Parameters:
WIDTH, 8, data width; must match the attached LIFO.
DEPTH, 4, depth of the attached LIFO.
LEVEL_WIDTH, `CLOG2(DEPTH+2), width of the occupancy counter (counts 0..DEPTH+1).

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
s_valid  input  1  push request
s_ready  output  1  push accepted when s_valid&s_ready
s_data  input  WIDTH  push data
m_valid  output  1  top-of-stack available
m_ready  input  1  pop when m_valid&m_ready
m_data  output  WIDTH  top-of-stack data, registered
level  output  LEVEL_WIDTH  total entries held (register + LIFO)
lifo_full  input  1  LIFO full flag
lifo_empty  input  1  LIFO empty flag
lifo_write_enable  output  1  LIFO push strobe
lifo_write_data  output  WIDTH  LIFO push data
lifo_read_enable  output  1  LIFO pop strobe
lifo_read_data  input  WIDTH  LIFO top entry; combinational, valid when !lifo_empty

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- State: tos_valid, tos_data[WIDTH], level. m_valid = tos_valid and m_data = tos_data.
- Reset: tos_valid=0, tos_data=0, level=0. lifo_write_enable and lifo_read_enable are 0 while reset is high. Reset mid-operation discards tos contents; the LIFO must be reset in the same cycle.
- Handshake: s_ready = !(tos_valid && lifo_full), combinational, independent of m_ready. push = s_valid&s_ready; pop = m_valid&m_ready.
- Cycle rules, mutually exclusive:
  - push only, !tos_valid: tos_data<=s_data; tos_valid<=1; no LIFO access; level+1.
  - push only, tos_valid: lifo_write_enable=1 with lifo_write_data=tos_data (spill); tos_data<=s_data; level+1.
  - pop only, !lifo_empty: lifo_read_enable=1; tos_data<=lifo_read_data (refill); level-1.
  - pop only, lifo_empty: tos_valid<=0; tos_data holds; level-1.
  - push and pop together (implies tos_valid): tos_data<=s_data; no LIFO access; level unchanged.
  - neither: hold.
- lifo_write_enable and lifo_read_enable are never both 1 in the same cycle.
- Latency: a pushed item is visible on m_data the cycle after acceptance. A popped item's successor is visible the next cycle; there are no bubbles.
- Full boundary: when level=DEPTH+1, s_ready=0; a pop in that cycle still completes.
- Empty boundary: when level=0, m_valid=0.
- level never wraps; reaching DEPTH+2 or underflowing is a design error (assertion in bench).
- m_valid and m_data are stable while m_valid&!m_ready, unless a push lands. A push replaces the top, which is correct LIFO semantics.

Optional Feature:
LIFO_TOP_CACHE_WATERMARK_EN
- Defined: adds output max_level[LEVEL_WIDTH].
  - Reset to 0.
  - Updates each cycle to max(max_level, next level), so it is visible the cycle after the level change.
  - Additional input watermark_clear (1 bit): when high, max_level<=next level; clear wins over update.
- Undefined: neither port exists and there is no extra logic.

Test Plan:
- WIDTH=8, DEPTH=4: after reset -> m_valid=0, s_ready=1, level=0, no LIFO strobes.
- Push 0x11 with m_ready=0 -> next cycle m_valid=1, m_data=0x11, level=1, lifo_write_enable never asserted.
- Push 0x11,0x22,0x33,0x44,0x55 -> four spills write 0x11..0x44 in order; m_data=0x55; level=5; s_ready=0 while s_valid=1 is held.
- From level=5, hold m_ready=1 -> m_data sequence 0x55,0x44,0x33,0x22,0x11 on consecutive cycles, then m_valid=0; level=0; four lifo_read_enable pulses.
- tos=0x22 over LIFO{0x11}, push 0xAA with m_ready=1 in the same cycle -> m_data=0xAA, level unchanged at 2, no LIFO strobes.
- With watermark enabled: fill to level 3, pop to 1 -> max_level=3. Pulse watermark_clear -> max_level=1.

Source files
------------

// File: rtl/lifo_top_cache.sv
// Stream front end for a LIFO: holds the top-of-stack in a register and spills older entries to the LIFO.
// Optional high-water mark output enabled by defining LIFO_TOP_CACHE_WATERMARK_EN.
module lifo_top_cache #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int LEVEL_WIDTH = $clog2(DEPTH + 2)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic [LEVEL_WIDTH-1:0] level,
    input  logic                   lifo_full,
    input  logic                   lifo_empty,
    output logic                   lifo_write_enable,
    output logic [WIDTH-1:0]       lifo_write_data,
    output logic                   lifo_read_enable,
    input  logic [WIDTH-1:0]       lifo_read_data
`ifdef LIFO_TOP_CACHE_WATERMARK_EN
    ,
    input  logic                   watermark_clear,
    output logic [LEVEL_WIDTH-1:0] max_level
`endif
);

    logic                   r_tos_valid;
    logic [WIDTH-1:0]       r_tos_data;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   w_push;
    logic                   w_pop;
    logic [LEVEL_WIDTH-1:0] w_level_next;

    // Room exists unless both the register and the LIFO are occupied to the brim.
    assign s_ready = !(r_tos_valid && lifo_full);
    assign m_valid = r_tos_valid;
    assign m_data  = r_tos_data;
    assign level   = r_level;

    // A simultaneous push and pop just replaces the top, so only lone pushes spill and lone pops refill.
    assign lifo_write_enable = !reset && w_push && !w_pop && r_tos_valid;
    assign lifo_write_data   = r_tos_data;
    assign lifo_read_enable  = !reset && w_pop && !w_push && !lifo_empty;

    // Handshake decode and next occupancy.
    always_comb begin
        w_push       = s_valid && s_ready;
        w_pop        = r_tos_valid && m_ready;
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LEVEL_WIDTH'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LEVEL_WIDTH'(1);
        end else begin
            w_level_next = r_level;
        end
    end

    // Top-of-stack register and occupancy counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tos_valid <= 1'b0;
            r_tos_data  <= {WIDTH{1'b0}};
            r_level     <= {LEVEL_WIDTH{1'b0}};
        end else begin
            r_level <= w_level_next;
            case ({w_push, w_pop})
                2'b11: r_tos_data <= s_data;
                2'b10: begin
                    r_tos_data  <= s_data;
                    r_tos_valid <= 1'b1;
                end
                2'b01: begin
                    if (!lifo_empty) begin
                        r_tos_data <= lifo_read_data;
                    end else begin
                        r_tos_valid <= 1'b0;
                    end
                end
                default: begin
                    r_tos_valid <= r_tos_valid;
                end
            endcase
        end
    end

`ifdef LIFO_TOP_CACHE_WATERMARK_EN
    logic [LEVEL_WIDTH-1:0] r_max_level;
    assign max_level = r_max_level;

    // High-water mark tracks the next level; a clear restarts it from the next level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_max_level <= {LEVEL_WIDTH{1'b0}};
        end else if (watermark_clear) begin
            r_max_level <= w_level_next;
        end else if (w_level_next > r_max_level) begin
            r_max_level <= w_level_next;
        end else begin
            r_max_level <= r_max_level;
        end
    end
`endif

endmodule

// File: tb/tb_lifo_top_cache.sv
// Randomized bench for lifo_top_cache: a queue-based stack model plus a behavioural attached LIFO.
module tb_lifo_top_cache;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 2);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic [LW-1:0]    level;
    logic             lifo_full;
    logic             lifo_empty;
    logic             lifo_write_enable;
    logic [WIDTH-1:0] lifo_write_data;
    logic             lifo_read_enable;
    logic [WIDTH-1:0] lifo_read_data;
    logic             watermark_clear = 1'b0;
`ifdef LIFO_TOP_CACHE_WATERMARK_EN
    logic [LW-1:0]    max_level;
`endif

    lifo_top_cache #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level),
        .lifo_full(lifo_full), .lifo_empty(lifo_empty),
        .lifo_write_enable(lifo_write_enable), .lifo_write_data(lifo_write_data),
        .lifo_read_enable(lifo_read_enable), .lifo_read_data(lifo_read_data)
`ifdef LIFO_TOP_CACHE_WATERMARK_EN
        , .watermark_clear(watermark_clear), .max_level(max_level)
`endif
    );

    always #5 clock = ~clock;

    // Behavioural attached LIFO.
    logic [WIDTH-1:0] lifo_mem [DEPTH];
    int               lifo_cnt = 0;
    assign lifo_full      = (lifo_cnt == DEPTH);
    assign lifo_empty     = (lifo_cnt == 0);
    assign lifo_read_data = lifo_empty ? '0 : lifo_mem[lifo_cnt - 1];

    always @(posedge clock) begin
        if (reset) begin
            lifo_cnt <= 0;
        end else if (lifo_write_enable && lifo_cnt < DEPTH) begin
            lifo_mem[lifo_cnt] <= lifo_write_data;
            lifo_cnt <= lifo_cnt + 1;
        end else if (lifo_read_enable && lifo_cnt > 0) begin
            lifo_cnt <= lifo_cnt - 1;
        end
    end

    // Reference model: the whole stack as a queue, top at the back.
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_data = '0;
    int               exp_max  = 0;
    int               n_vec    = 0;
    int               n_bad    = 0;
    int               n_re     = 0;
    int               n_we     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, advance the model, then cross the edge.
    task automatic cycle(input logic rst, input logic sv, input logic [WIDTH-1:0] sd,
                         input logic mr, input logic clr);
        int  sz;
        bit  push, pop, e_we, e_re;
        reset = rst; s_valid = sv; s_data = sd; m_ready = mr; watermark_clear = clr;
        #4;
        sz   = model_q.size();
        push = sv && (sz < DEPTH + 1);
        pop  = (sz > 0) && mr;
        e_we = !rst && push && !pop && (sz > 0);
        e_re = !rst && pop && !push && (sz >= 2);
        chk("m_valid", 32'(m_valid), 32'(sz > 0));
        chk("m_data", 32'(m_data), 32'(exp_data));
        chk("level", 32'(level), 32'(sz));
        chk("s_ready", 32'(s_ready), 32'(sz < DEPTH + 1));
        chk("write_enable", 32'(lifo_write_enable), 32'(e_we));
        chk("read_enable", 32'(lifo_read_enable), 32'(e_re));
        if (e_we) chk("write_data", 32'(lifo_write_data), 32'(model_q[sz - 1]));
`ifdef LIFO_TOP_CACHE_WATERMARK_EN
        chk("max_level", 32'(max_level), 32'(exp_max));
`endif
        if (lifo_read_enable) n_re++;
        if (lifo_write_enable) n_we++;
        if (rst) begin
            model_q.delete();
            exp_data = '0;
            exp_max  = 0;
        end else begin
            if (push && pop) begin
                void'(model_q.pop_back());
                model_q.push_back(sd);
                exp_data = sd;
            end else if (push) begin
                model_q.push_back(sd);
                exp_data = sd;
            end else if (pop) begin
                void'(model_q.pop_back());
                if (model_q.size() > 0) exp_data = model_q[model_q.size() - 1];
            end
            if (clr) exp_max = model_q.size();
            else if (model_q.size() > exp_max) exp_max = model_q.size();
        end
        @(posedge clock);
        #1;
    endtask

    logic [WIDTH-1:0] pops_exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [WIDTH-1:0] push_val [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        int pw, pr, re0;
        @(posedge clock);
        #1;
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("pin_reset_mvalid", 32'(m_valid), 32'd0);
        chk("pin_reset_sready", 32'(s_ready), 32'd1);
        chk("pin_reset_level", 32'(level), 32'd0);

        // Single push, then fill to the brim.
        cycle(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        chk("pin_push1_data", 32'(m_data), 32'h11);
        chk("pin_push1_level", 32'(level), 32'd1);
        chk("pin_push1_no_we", 32'(n_we), 32'd0);
        for (int i = 1; i < 5; i++) cycle(1'b0, 1'b1, push_val[i], 1'b0, 1'b0);
        chk("pin_full_data", 32'(m_data), 32'h55);
        chk("pin_full_level", 32'(level), 32'd5);
        chk("pin_spill_count", 32'(n_we), 32'd4);
        for (int i = 0; i < 4; i++) chk("pin_spill_order", 32'(lifo_mem[i]), 32'(push_val[i]));
        cycle(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
        chk("pin_full_sready", 32'(s_ready), 32'd0);
        chk("pin_full_hold", 32'(m_data), 32'h55);

        // Drain with m_ready held.
        re0 = n_re;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            chk("pin_pop_data", 32'(m_data), 32'(pops_exp[i]));
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pin_drain_mvalid", 32'(m_valid), 32'd0);
        chk("pin_drain_level", 32'(level), 32'd0);
        chk("pin_drain_reads", 32'(n_re - re0), 32'd4);

        // Simultaneous push and pop replaces the top.
        cycle(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        re0 = n_re; pw = n_we;
        cycle(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("pin_swap_data", 32'(m_data), 32'hAA);
        chk("pin_swap_level", 32'(level), 32'd2);
        chk("pin_swap_strobes", 32'((n_re - re0) + (n_we - pw)), 32'd0);

`ifdef LIFO_TOP_CACHE_WATERMARK_EN
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, push_val[i], 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pin_wm_max", 32'(max_level), 32'd3);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("pin_wm_clear", 32'(max_level), 32'd1);
`endif

        // Randomized phases with varying push/pop bias.
        for (int ph = 0; ph < 15; ph++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int c = 0; c < 200; c++) begin
                cycle(($urandom_range(0, 99) == 0),
                      ($urandom_range(0, 99) < pw),
                      WIDTH'($urandom),
                      ($urandom_range(0, 99) < pr),
                      ($urandom_range(0, 15) == 0));
            end
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
